zion_basic_circuit_lib_rsp_skid_slice: RTL and testbench
========================================================

Name: zion_basic_circuit_lib_rsp_skid_slice

Overview:
Pipeline register slice with a valid/ready handshake. It sequences two data registers, a main register and a skid register, so a datapath can be cut for timing without losing throughput. Both oRdy and oVld come straight from flops, which breaks combinational paths in both directions. It sits between any producer/consumer pair in the basic circuit library that needs a registered stage with backpressure.

Parameters:
WIDTH_IN, "_", width of iDat; must be set by the instantiating code.
WIDTH_OUT, "_", width of oDat; must equal WIDTH_IN.
INI_DATA, '0, value loaded into both data registers on reset.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset; synchronous, active-high.
iVld  input  1  upstream beat valid.
oRdy  output  1  ready to upstream; registered.
iDat  input  WIDTH_IN  upstream data.
oVld  output  1  downstream beat valid; registered.
iRdy  input  1  downstream ready.
oDat  output  WIDTH_OUT  downstream data; the main register.
iFlush  input  1  discard all held beats.
oCnt  output  2  occupancy: 0, 1 or 2 beats held.

Behaviour:
- Handshake rules:
  - Accept occurs on a cycle with iVld & oRdy.
  - Deliver occurs on a cycle with oVld & iRdy.
  - Upstream may not retract iVld before acceptance; the slice does not check this.
- State machine, state st:
  - EMPTY: oVld=0, oRdy=1, oCnt=0.
  - BUSY: oVld=1, oRdy=1, oCnt=1.
  - FULL: oVld=1, oRdy=0, oCnt=2.
- Outputs are pure decodes of st, so all are registered.
- EMPTY:
  - iVld: main<=iDat, go to BUSY.
  - Otherwise stay in EMPTY.
- BUSY:
  - iVld & iRdy: main<=iDat, stay in BUSY.
  - iVld & !iRdy: skid<=iDat, go to FULL.
  - !iVld & iRdy: go to EMPTY.
  - Otherwise hold.
- FULL:
  - iRdy: main<=skid, go to BUSY.
  - Otherwise hold.
  - iVld is ignored because oRdy=0.
- Latency: an accepted beat appears on oDat/oVld the cycle after acceptance. Throughput is 1 beat/cycle while iRdy stays high.
- Ordering: FIFO order always; the skid beat is never delivered before the main beat.
- Stability: while oVld & !iRdy, oDat and oVld hold unchanged.
- Flush:
  - iFlush=1 forces st<=EMPTY next cycle. Data registers are unchanged.
  - Flush takes priority over accept and deliver in the same cycle. A beat offered in that cycle (oRdy may be 1) is discarded.
  - A deliver in the flush cycle still counts downstream, because the handshake already completed.
- Reset:
  - rst has priority over iFlush and the handshake.
  - Next cycle: st=EMPTY, main=INI_DATA, skid=INI_DATA, oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA.
  - Reset mid-operation drops held beats with no partial delivery.
- Width: data is copied without conversion.
- Parameter check: an initial check reports $error("Parameter Error: skid slice IO width mismatch!!") when WIDTH_IN != WIDTH_OUT, and calls $finish under CHECK_ERR_EXIT.
- Assertions: st never takes an encoding outside EMPTY/BUSY/FULL; oRdy==0 implies oCnt==2.

Decomposition:
- Shared package zion_basic_circuit_lib_pkg holds:
  - typedef enum logic [1:0] {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2} skid_st_e;
  - localparam SKID_DEPTH=2.
- One natural sub-module, zion_basic_circuit_lib_rsp_en_dff:
  - Data register with synchronous active-high reset to INI_DATA and a load enable.
  - Instantiated twice, for main (muxed input iDat/skid) and skid.

Test Plan:
- Reset: rst=1 for 2 cycles with INI_DATA=8'hA5 -> oVld=0, oRdy=1, oCnt=0, oDat=8'hA5.
- Streaming: iRdy=1, iVld=1, iDat=1,2,3,4 on consecutive cycles -> oDat=1,2,3,4 with oVld=1 each cycle starting one cycle later; oRdy stays 1.
- Backpressure/skid: in BUSY holding 8'h10, drop iRdy and offer 8'h11 -> FULL, oRdy=0, oCnt=2, oDat holds 8'h10. Raise iRdy -> delivers 8'h10 then 8'h11; offered 8'h12 is not accepted until oRdy=1.
- Flush: in FULL, pulse iFlush with iVld=1, iDat=8'h33 -> next cycle EMPTY, oVld=0, oCnt=0, 8'h33 never appears on oDat.
- Reset mid-operation: in FULL, assert rst together with iFlush and iRdy -> next cycle oDat=INI_DATA, oVld=0, oRdy=1, no stale beat is delivered afterward.
- Random: iVld and iRdy random at 50% for 10k cycles against a scoreboard -> no loss, no duplication, in-order delivery, and the oRdy/oCnt assertions hold.

Source files
------------

// File: rtl/zion_basic_circuit_lib_pkg.sv
// ----------------------------------------------------------------------------
// zion_basic_circuit_lib_pkg
//   Shared types and constants for the basic circuit library.
//   - skid_st_e       : state encoding of the response skid slice
//   - SKID_DEPTH      : number of beats the skid slice can hold
//   - skid_occupancy  : maps a skid slice state to its beat count
// ----------------------------------------------------------------------------
package zion_basic_circuit_lib_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_st_e;

    localparam int SKID_DEPTH = 2;

    // Beats held in each state; FULL means both main and skid are occupied.
    function automatic logic [1:0] skid_occupancy(input skid_st_e st);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (st)
            EMPTY:   cnt = 2'd0;
            BUSY:    cnt = 2'd1;
            FULL:    cnt = 2'(SKID_DEPTH);
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_rsp_en_dff.sv
// ----------------------------------------------------------------------------
// zion_basic_circuit_lib_rsp_en_dff
//   Data register with load enable and synchronous active-high reset.
//   Ports:
//     clk : clock, updates on posedge
//     rst : synchronous reset, loads INI_DATA
//     en  : load enable
//     d   : data in
//     q   : registered data out
// ----------------------------------------------------------------------------
module zion_basic_circuit_lib_rsp_en_dff #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: data registers are reset here so oDat shows a defined INI_DATA
    // after reset; sequential state always uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INI_DATA;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_rsp_skid_slice.sv
// ----------------------------------------------------------------------------
// zion_basic_circuit_lib_rsp_skid_slice
//   Valid/ready register slice with a main and a skid data register. oRdy and
//   oVld are pure decodes of the state register, so neither direction has a
//   combinational path through the slice.
//   Ports:
//     clk    : clock, updates on posedge
//     rst    : synchronous active-high reset (priority over everything)
//     iVld   : upstream valid          oRdy : ready to upstream (registered)
//     iDat   : upstream data           oVld : downstream valid (registered)
//     iRdy   : downstream ready        oDat : downstream data (main register)
//     iFlush : drop all held beats     oCnt : beats held (0..2)
// ----------------------------------------------------------------------------
module zion_basic_circuit_lib_rsp_skid_slice
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int                    WIDTH_IN  = 8,
    parameter int                    WIDTH_OUT = 8,
    parameter logic [WIDTH_IN-1:0]   INI_DATA  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat,
    input  logic                 iFlush,
    output logic [1:0]           oCnt
);

    // Width mismatch is caught at elaboration time.
    if (WIDTH_IN != WIDTH_OUT) begin : g_width_err
`ifdef CHECK_ERR_EXIT
        $fatal(1, "Parameter Error: skid slice IO width mismatch!!");
`else
        $error("Parameter Error: skid slice IO width mismatch!!");
`endif
    end

    skid_st_e            st;
    skid_st_e            st_nxt;
    logic                main_en;
    logic                main_from_skid;
    logic                skid_en;
    logic [WIDTH_IN-1:0] main_d;
    logic [WIDTH_IN-1:0] main_q;
    logic [WIDTH_IN-1:0] skid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= EMPTY;
        end else begin
            st <= st_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is
    // inferred on paths that leave it unassigned.
    always_comb begin
        st_nxt         = st;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (st)
            EMPTY: begin
                if (iVld) begin
                    main_en = 1'b1;
                    st_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (iVld && iRdy) begin
                    main_en = 1'b1;
                end else if (iVld) begin
                    // Downstream stalled: park the new beat behind main.
                    skid_en = 1'b1;
                    st_nxt  = FULL;
                end else if (iRdy) begin
                    st_nxt  = EMPTY;
                end
            end
            FULL: begin
                // oRdy is low here, so iVld cannot be accepted.
                if (iRdy) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    st_nxt         = BUSY;
                end
            end
            default: st_nxt = EMPTY;
        endcase

        // Flush wins over accept and deliver; data registers keep contents.
        if (iFlush) begin
            st_nxt  = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : iDat;

    zion_basic_circuit_lib_rsp_en_dff #(
        .WIDTH    (WIDTH_IN),
        .INI_DATA (INI_DATA)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    zion_basic_circuit_lib_rsp_en_dff #(
        .WIDTH    (WIDTH_IN),
        .INI_DATA (INI_DATA)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (iDat),
        .q   (skid_q)
    );

    always_comb begin
        oVld = 1'b0;
        oRdy = 1'b1;
        case (st)
            EMPTY:   begin oVld = 1'b0; oRdy = 1'b1; end
            BUSY:    begin oVld = 1'b1; oRdy = 1'b1; end
            FULL:    begin oVld = 1'b1; oRdy = 1'b0; end
            default: begin oVld = 1'b0; oRdy = 1'b1; end
        endcase
    end

    assign oCnt = skid_occupancy(st);
    assign oDat = main_q;

`ifndef SYNTHESIS
    a_st_legal : assert property (@(posedge clk) disable iff (rst)
        st inside {EMPTY, BUSY, FULL})
        else $error("skid slice: illegal state encoding");

    a_rdy_cnt : assert property (@(posedge clk) disable iff (rst)
        !oRdy |-> (oCnt == 2'(SKID_DEPTH)))
        else $error("skid slice: oRdy low while not full");
`endif

endmodule

// File: tb/tb_zion_basic_circuit_lib_rsp_skid_slice.sv
// ----------------------------------------------------------------------------
// Bench for zion_basic_circuit_lib_rsp_skid_slice. The reference model is a
// bounded FIFO (queue of up to two beats): accept when fewer than two beats
// are held, deliver the head when at least one is held, flush/reset empty it.
// ----------------------------------------------------------------------------
module tb_zion_basic_circuit_lib_rsp_skid_slice;

    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'hA5;

    logic         clk;
    logic         rst;
    logic         iVld;
    logic         oRdy;
    logic [W-1:0] iDat;
    logic         oVld;
    logic         iRdy;
    logic [W-1:0] oDat;
    logic         iFlush;
    logic [1:0]   oCnt;

    zion_basic_circuit_lib_rsp_skid_slice #(
        .WIDTH_IN  (W),
        .WIDTH_OUT (W),
        .INI_DATA  (INI)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iVld   (iVld),
        .oRdy   (oRdy),
        .iDat   (iDat),
        .oVld   (oVld),
        .iRdy   (iRdy),
        .oDat   (oDat),
        .iFlush (iFlush),
        .oCnt   (oCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] q[$];
    bit         model_ok = 1'b0;

    // Called at a negedge: check the outputs registered at the previous
    // posedge against the model, drive inputs, advance the model for the
    // coming posedge, then wait for the next negedge.
    task automatic step(input logic vld, input logic [7:0] dat, input logic rdy,
                        input logic fl, input logic rs);
        bit acc;
        bit dlv;
        if (model_ok) begin
            check("vld", oVld, (q.size() > 0));
            check("rdy", oRdy, (q.size() < 2));
            check("cnt", oCnt, q.size());
            if (q.size() > 0) check("dat", oDat, q[0]);
        end
        iVld = vld; iDat = dat; iRdy = rdy; iFlush = fl; rst = rs;
        if (rs) begin
            q.delete();
            model_ok = 1'b1;
        end else begin
            acc = vld && (q.size() < 2);
            dlv = rdy && (q.size() > 0);
            if (dlv) void'(q.pop_front());
            if (fl) q.delete();
            else if (acc) q.push_back(dat);
        end
        @(negedge clk);
    endtask

    initial begin
        iVld = 1'b0; iDat = '0; iRdy = 1'b0; iFlush = 1'b0; rst = 1'b1;
        @(negedge clk);

        // Reset for two cycles.
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        check("rst_dat", oDat, INI);
        check("rst_vld", oVld, 1'b0);
        check("rst_rdy", oRdy, 1'b1);
        check("rst_cnt", oCnt, 2'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        check("stream_last", oDat, 8'h04);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid register.
        step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check("bp_full_rdy", oRdy, 1'b0);
        check("bp_full_cnt", oCnt, 2'd2);
        check("bp_hold_dat", oDat, 8'h10);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        check("bp_skid_dat", oDat, 8'h11);
        step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush while full, with a beat offered in the same cycle.
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        check("flush_vld", oVld, 1'b0);
        check("flush_cnt", oCnt, 2'd0);
        check("flush_dat_kept", oDat, 8'h20);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, together with flush and ready.
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b1, 1'b1, 1'b1);
        check("mrst_dat", oDat, INI);
        check("mrst_vld", oVld, 1'b0);
        check("mrst_rdy", oRdy, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0), 1'b0);
        end
        // Drain, then one final comparison of outputs.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("drain_cnt", oCnt, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
